// File: rtl/dpram_rd_ctrl.sv
// dpram_rd_ctrl: read-side burst controller for the simple dual-port RAM.
// Takes a (start address, word count) command, issues RAM reads under a
// 4-credit limit, realigns returned words to the RAM read latency and
// presents them through a 4-entry buffer as a valid/ready stream.
// Optional feature: define DPRAM_RD_CTRL_STALL_CNT_EN to add o_stall_cnt,
// a saturating count of stalled output cycles.
module dpram_rd_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LEN_WIDTH  = 11,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
    output logic                  o_ram_en,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_data,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic                  o_m_valid,
    output logic                  o_m_last,
    input  logic                  i_m_ready,
    output logic                  o_busy,
    output logic                  o_done
`ifdef DPRAM_RD_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]           o_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;

    logic [RD_LATENCY-1:0]   pipe_v_q, pipe_v_d;
    logic [RD_LATENCY-1:0]   pipe_l_q, pipe_l_d;

    logic [DATA_WIDTH-1:0]   buf_data_q [4];
    logic [3:0]              buf_last_q;
    logic [1:0]              wr_ptr_q, wr_ptr_d;
    logic [1:0]              rd_ptr_q, rd_ptr_d;
    logic [2:0]              cnt_q, cnt_d;

    logic [2:0]              inflight;
    logic                    credit_ok;
    logic                    issue;
    logic                    issue_last;
    logic                    push;
    logic                    push_last;
    logic                    pop;
    logic                    accept;

    // Credit accounting: reads in the latency pipe plus words held in the buffer.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + {2'b00, pipe_v_q[i]};
        end
    end

    assign credit_ok  = (cnt_q + inflight) < 3'd4;
    assign issue      = (state_q == ST_READ) && (rem_q != '0) && credit_ok;
    assign issue_last = issue && (rem_q == LEN_WIDTH'(1));
    assign push       = pipe_v_q[RD_LATENCY-1];
    assign push_last  = pipe_l_q[RD_LATENCY-1];
    assign pop        = o_m_valid && i_m_ready;
    assign accept     = i_cmd_valid && (state_q == ST_IDLE);

    // FSM next state, read pointer and remaining-word counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ptr_d   = i_cmd_addr;
                    rem_d   = i_cmd_len;
                    state_d = (i_cmd_len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (issue) begin
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && o_m_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, pointer and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

    // Latency pipe next value: shift {valid, last} of each issued read.
    always_comb begin
        pipe_v_d    = pipe_v_q;
        pipe_l_d    = pipe_l_q;
        pipe_v_d[0] = issue;
        pipe_l_d[0] = issue_last;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_l_d[i] = pipe_l_q[i-1];
        end
    end

    // Latency pipe registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_v_q <= '0;
            pipe_l_q <= '0;
        end else begin
            pipe_v_q <= pipe_v_d;
            pipe_l_q <= pipe_l_d;
        end
    end

    // Output buffer pointer and occupancy update.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 3'd1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    // Output buffer storage; the credit rule guarantees a free slot on every push.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                buf_data_q[i] <= '0;
            end
            buf_last_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            if (push) begin
                buf_data_q[wr_ptr_q] <= i_ram_data;
                buf_last_q[wr_ptr_q] <= push_last;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_cmd_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
    assign o_ram_en    = issue;
    assign o_ram_addr  = ptr_q;
    assign o_m_valid   = (cnt_q != '0);
    assign o_m_data    = buf_data_q[rd_ptr_q];
    assign o_m_last    = o_m_valid && buf_last_q[rd_ptr_q];

`ifdef DPRAM_RD_CTRL_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Stall counter next value: cleared on accept, saturating, frozen in IDLE.
    always_comb begin
        stall_d = stall_q;
        if (accept) begin
            stall_d = '0;
        end else if ((state_q != ST_IDLE) && o_m_valid && !i_m_ready && (stall_q != '1)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dpram_rd_ctrl.sv
// Self-checking bench for dpram_rd_ctrl. Two instances (RD_LATENCY 1 and 2)
// share the same command and ready stimulus; each has its own RAM model and
// its own burst-level reference model in the compare process.
`timescale 1ns/1ps
module tb_dpram_rd_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = 11;

    localparam logic [9:0] PIN_DATA  [4] = '{10'h010, 10'h011, 10'h012, 10'h013};
    localparam logic       PIN_LAST  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [9:0] PIN_WRAP  [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    localparam int         PIN_FIRST [2] = '{3, 4};

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          m_ready;

    logic [1:0]    cmd_ready, ram_en, m_valid, m_last, busy, done;
    logic [AW-1:0] ram_addr [2];
    logic [DW-1:0] ram_data [2];
    logic [DW-1:0] m_data   [2];
`ifdef DPRAM_RD_CTRL_STALL_CNT_EN
    logic [15:0]   stall_cnt [2];
    int            stall_m   [2];
`endif

    logic [DW-1:0] ram [1024];

    int checks;
    int errors;
    int tmo_cnt;
    int tmo_seen;
    int rdy_mode;
    int cyc;

    // Reference model state, per lane
    logic [AW-1:0] b_addr [2];
    int            b_len  [2];
    int            n_iss  [2];
    int            n_ret  [2];
    int            n_pop  [2];
    int            acc_cyc[2];
    logic [3:0]    hist   [2];
    logic [1:0]    busy_m;
    logic [1:0]    done_m;
    logic [1:0]    seen_first;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [DW-1:0] rd1;

        dpram_rd_ctrl #(
            .DATA_WIDTH(DW),
            .ADDR_WIDTH(AW),
            .LEN_WIDTH (LW),
            .RD_LATENCY(g + 1)
        ) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_cmd_valid(cmd_valid),
            .o_cmd_ready(cmd_ready[g]),
            .i_cmd_addr (cmd_addr),
            .i_cmd_len  (cmd_len),
            .o_ram_en   (ram_en[g]),
            .o_ram_addr (ram_addr[g]),
            .i_ram_data (ram_data[g]),
            .o_m_data   (m_data[g]),
            .o_m_valid  (m_valid[g]),
            .o_m_last   (m_last[g]),
            .i_m_ready  (m_ready),
            .o_busy     (busy[g]),
`ifdef DPRAM_RD_CTRL_STALL_CNT_EN
            .o_done     (done[g]),
            .o_stall_cnt(stall_cnt[g])
`else
            .o_done     (done[g])
`endif
        );

        always @(posedge clk) begin
            if (ram_en[g]) rd1 <= ram[ram_addr[g]];
        end

        if (g == 0) begin : g_lat1
            assign ram_data[g] = rd1;
        end else begin : g_lat2
            logic [DW-1:0] rd2;
            always @(posedge clk) rd2 <= rd1;
            assign ram_data[g] = rd2;
        end
    end

    task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d cyc=%0d got=%0h want=%0h", nm, l, cyc, act, exp);
        end
    endtask

    // Compare process: one burst-level model per lane, checked every cycle.
    always @(negedge clk) begin
        cyc++;
        if (tmo_cnt != tmo_seen) begin
            chk("timeout", -1, 32'(tmo_cnt), 32'(tmo_seen));
            tmo_seen = tmo_cnt;
        end
        for (int l = 0; l < 2; l++) begin
            int   lat;
            bit   en_e, v_e, hs, done_nx, busy_nx;
            lat = l + 1;
            if (!rst_n) begin
                chk("rst_cmd_ready", l, cmd_ready[l], 1);
                chk("rst_busy",      l, busy[l],      0);
                chk("rst_done",      l, done[l],      0);
                chk("rst_ram_en",    l, ram_en[l],    0);
                chk("rst_ram_addr",  l, ram_addr[l],  0);
                chk("rst_m_valid",   l, m_valid[l],   0);
                chk("rst_m_last",    l, m_last[l],    0);
                chk("rst_m_data",    l, m_data[l],    0);
`ifdef DPRAM_RD_CTRL_STALL_CNT_EN
                chk("rst_stall_cnt", l, stall_cnt[l], 0);
                stall_m[l] = 0;
`endif
                busy_m[l] = 1'b0;
                done_m[l] = 1'b0;
                b_len[l]  = 0;
                n_iss[l]  = 0;
                n_ret[l]  = 0;
                n_pop[l]  = 0;
                hist[l]   = '0;
                acc_cyc[l] = -100;
                seen_first[l] = 1'b0;
            end else begin
                if (hist[l][lat]) n_ret[l]++;
                en_e = busy_m[l] && (n_iss[l] < b_len[l]) && ((n_iss[l] - n_pop[l]) < 4);
                v_e  = n_ret[l] > n_pop[l];

                chk("busy",      l, busy[l],      busy_m[l]);
                chk("cmd_ready", l, cmd_ready[l], !busy_m[l]);
                chk("done",      l, done[l],      done_m[l]);
                chk("ram_en",    l, ram_en[l],    en_e);
                if (en_e && ram_en[l]) begin
                    chk("ram_addr", l, ram_addr[l], 32'(10'(b_addr[l] + n_iss[l])));
                    if (b_addr[l] == 10'h3FE && b_len[l] == 4 && n_iss[l] < 4)
                        chk("pin_wrap_addr", l, ram_addr[l], PIN_WRAP[n_iss[l]]);
                end
                chk("m_valid", l, m_valid[l], v_e);
`ifdef DPRAM_RD_CTRL_STALL_CNT_EN
                chk("stall_cnt", l, stall_cnt[l], 32'(stall_m[l]));
`endif
                if (v_e && m_valid[l]) begin
                    chk("m_data", l, m_data[l], ram[10'(b_addr[l] + n_pop[l])]);
                    chk("m_last", l, m_last[l], n_pop[l] == b_len[l] - 1);
                    if (b_addr[l] == 10'h010 && b_len[l] == 4 && n_pop[l] < 4) begin
                        chk("pin_data", l, m_data[l][9:0], PIN_DATA[n_pop[l]]);
                        chk("pin_last", l, m_last[l], PIN_LAST[n_pop[l]]);
                        if (!seen_first[l])
                            chk("pin_first_valid", l, 32'(cyc - acc_cyc[l]), 32'(PIN_FIRST[l]));
                    end
                    seen_first[l] = 1'b1;
                end

                hs      = v_e && m_valid[l] && m_ready;
                done_nx = 1'b0;
                if (hs) begin
                    if (n_pop[l] == b_len[l] - 1) done_nx = 1'b1;
                    n_pop[l]++;
                end
                if (en_e) n_iss[l]++;
                hist[l] = {hist[l][2:0], en_e};
`ifdef DPRAM_RD_CTRL_STALL_CNT_EN
                if (busy_m[l] && v_e && !m_ready && stall_m[l] != 65535) stall_m[l]++;
`endif
                busy_nx = done_m[l] ? 1'b0 : busy_m[l];
                if (cmd_valid && !busy_m[l]) begin
                    b_addr[l]  = cmd_addr;
                    b_len[l]   = int'(cmd_len);
                    n_iss[l]   = 0;
                    n_ret[l]   = 0;
                    n_pop[l]   = 0;
                    acc_cyc[l] = cyc;
                    seen_first[l] = 1'b0;
                    busy_nx    = 1'b1;
                    if (cmd_len == '0) done_nx = 1'b1;
`ifdef DPRAM_RD_CTRL_STALL_CNT_EN
                    stall_m[l] = 0;
`endif
                end
                busy_m[l] = busy_nx;
                done_m[l] = done_nx;
            end
        end
    end

    // Downstream ready driver: 0 = high, 1 = low, 2 = random
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'b0;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (cmd_ready != 2'b11 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (cmd_ready != 2'b11) tmo_cnt++;
    endtask

    task automatic start_cmd(input logic [9:0] a, input int n, input bit garbage);
        wait_idle();
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = 11'(n);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (garbage && n != 0) begin
            repeat (2) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_addr  = 10'($urandom);
                cmd_len   = 11'($urandom_range(0, 30));
                @(posedge clk);
                #1;
            end
            cmd_valid = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] r;
        int k;
        int n;
        checks = 0; errors = 0; tmo_cnt = 0; tmo_seen = 0; cyc = 0;
        rdy_mode = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        for (int i = 0; i < 1024; i++) begin
            r = $urandom();
            ram[i] = {r[21:0], 10'(i)};
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Nominal burst, address wrap, zero-length command
        start_cmd(10'h010, 4, 1'b0); wait_idle();
        start_cmd(10'h3FE, 4, 1'b0); wait_idle();
        start_cmd(10'h155, 0, 1'b0); wait_idle();

        // Backpressure: ready low for 10 cycles, then random
        rdy_mode = 1;
        start_cmd(10'h200, 16, 1'b1);
        repeat (10) @(posedge clk);
        rdy_mode = 2;
        wait_idle();

        // Reset after 5 of 10 beats on the latency-1 lane, then a fresh burst
        rdy_mode = 0;
        start_cmd(10'h0A0, 10, 1'b0);
        k = 0;
        for (int t = 0; t < 200 && k < 5; t++) begin
            @(negedge clk);
            if (m_valid[0] && m_ready) k++;
        end
        if (k < 5) tmo_cnt++;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        start_cmd(10'h300, 2, 1'b0); wait_idle();

        // Held stall with data waiting
        rdy_mode = 1;
        start_cmd(10'h040, 4, 1'b0);
        repeat (12) @(posedge clk);
        rdy_mode = 0;
        wait_idle();

        // Randomized bursts
        for (int b = 0; b < 30; b++) begin
            rdy_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
            start_cmd(10'($urandom), n, 1'b1);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
